// File: rtl/agex_muldiv_seq.sv
// Iterative M-extension multiply/divide unit for the AGEX stage.
// Radix-2 shift-add multiply, restoring divide, sign fix-up at the end.
module agex_muldiv_seq #(
  parameter int XLEN    = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [XLEN-1:0]    req_a,
  input  logic [XLEN-1:0]    req_b,
  input  logic [REGBITS-1:0] req_wregno,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XLEN-1:0]    resp_data,
  output logic [REGBITS-1:0] resp_wregno,
  output logic               busy
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   d_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [CW-1:0]     cnt_q;

  logic              accept;
  logic              a_sop, b_sop, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              sign_in;
  logic              div0, ovf, special;
  logic [XLEN-1:0]   spec_data;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [XLEN-1:0]   fix_data;

  assign accept     = req_valid && (state == IDLE) && !flush;
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

  // Operand signedness, magnitudes and special-case detection at the request
  always_comb begin
    a_sop = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
            (req_op == OP_DIV)  || (req_op == OP_REM);
    b_sop = (req_op == OP_MULH) || (req_op == OP_DIV) ||
            (req_op == OP_REM);
    sa    = a_sop && req_a[XLEN-1];
    sb    = b_sop && req_b[XLEN-1];
    a_mag = sa ? (~req_a + ONE) : req_a;
    b_mag = sb ? (~req_b + ONE) : req_b;
    if (req_op == OP_REM)
      sign_in = sa;
    else if (req_op == OP_MUL)
      sign_in = 1'b0;
    else
      sign_in = sa ^ sb;
    div0    = req_op[2] && (req_b == '0);
    ovf     = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
              (req_a == MINV) && (req_b == '1);
    special = div0 || ovf;
    spec_data = '0;
    unique case (1'b1)
      div0 && !req_op[1]: spec_data = '1;
      div0 &&  req_op[1]: spec_data = req_a;
      ovf  && !req_op[1]: spec_data = MINV;
      default:            spec_data = '0;
    endcase
  end

  // One shift-add or shift-subtract step on the working registers
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, d_q};
    if (op_q[2]) begin
      hi_nx = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection; high half of -P borrows from low half
  always_comb begin
    fix_data = '0;
    unique case (op_q)
      OP_MUL:    fix_data = lo_q;
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  fix_data = neg_q ?
                   (~hi_q + {{(XLEN-1){1'b0}}, (lo_q == '0)}) : hi_q;
      OP_DIV,
      OP_DIVU:   fix_data = neg_q ? (~lo_q + ONE) : lo_q;
      OP_REM,
      OP_REMU:   fix_data = neg_q ? (~hi_q + ONE) : hi_q;
      default:   fix_data = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_nx = special ? DONE : CALC;
        CALC: if (cnt_q == CW'(XLEN - 1)) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: if (resp_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= '0;
      neg_q       <= 1'b0;
      d_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      resp_data   <= '0;
      resp_wregno <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q        <= req_op;
      neg_q       <= sign_in;
      d_q         <= req_op[2] ? b_mag : a_mag;
      lo_q        <= req_op[2] ? a_mag : b_mag;
      hi_q        <= '0;
      cnt_q       <= '0;
      resp_wregno <= req_wregno;
      if (special)
        resp_data <= spec_data;
    end else if (state == CALC) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q + 1'b1;
    end else if (state == FIX) begin
      resp_data <= fix_data;
    end
  end

endmodule
